// File: rtl/iob_dbus_split_pkg.sv
// rtl/iob_dbus_split_pkg.sv - bus field layout and width helpers for the IOb data-bus splitter
package iob_dbus_split_pkg;

   // Response bit positions: {rdata, rvalid, ready}
   localparam int RESP_READY_BIT  = 0;
   localparam int RESP_RVALID_BIT = 1;
   localparam int RESP_RDATA_LSB  = 2;

   // Request layout, MSB first: {valid, addr, wdata, wstrb}
   function automatic int req_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int resp_w(input int data_w);
      return data_w + 2;
   endfunction

   function automatic int req_addr_lsb(input int data_w);
      return data_w / 8 + data_w;
   endfunction

   function automatic int req_valid_bit(input int addr_w, input int data_w);
      return data_w / 8 + data_w + addr_w;
   endfunction

endpackage

// File: rtl/iob_dbus_split_if.sv
// rtl/iob_dbus_split_if.sv - master-side and slave-side IOb buses of the splitter
interface iob_dbus_split_if
   import iob_dbus_split_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int N_SLAVES = 4
);
   localparam int REQ_W  = req_w(ADDR_W, DATA_W);
   localparam int RESP_W = resp_w(DATA_W);

   logic [REQ_W-1:0]           m_req;
   logic [RESP_W-1:0]          m_resp;
   logic [N_SLAVES*REQ_W-1:0]  s_req;
   logic [N_SLAVES*RESP_W-1:0] s_resp;

   // Environment side: drives the CPU request and the slave responses
   modport master (
      output m_req,
      output s_resp,
      input  m_resp,
      input  s_req
   );

   // Splitter side
   modport slave (
      input  m_req,
      input  s_resp,
      output m_resp,
      output s_req
   );
endinterface

// File: rtl/iob_dbus_split_track.sv
// rtl/iob_dbus_split_track.sv - outstanding-read count, owning slave, stall and sticky error
module iob_dbus_split_track
   import iob_dbus_split_pkg::*;
#(
   parameter int SEL_W     = 2,
   parameter int N_SLAVES  = 4,
   parameter int MAX_OUTST = 4,
   parameter int CNT_W     = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SEL_W-1:0]    i_sel,
   input  logic                i_is_read,
   input  logic                i_accept,
   input  logic                i_decerr,
   input  logic [N_SLAVES-1:0] i_rvalid,
   input  logic                i_cur_rvalid,
   output logic                o_stall,
   output logic                o_pop,
   output logic [CNT_W-1:0]    o_cnt,
   output logic [SEL_W-1:0]    o_cur,
   output logic                o_err
);
   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTST);

   logic [CNT_W-1:0] r_cnt;
   logic [SEL_W-1:0] r_cur;
   logic             r_err;
   logic             w_busy;
   logic             w_full;
   logic             w_push;
   logic             w_spurious;

   assign w_busy  = (r_cnt != '0);
   assign w_full  = (r_cnt == LP_MAX);
   // A different target while reads are in flight would let responses overtake
   assign o_stall = (w_busy && (i_sel != r_cur)) || (i_is_read && w_full);
   assign o_pop   = w_busy && i_cur_rvalid;
   assign w_push  = i_accept && i_is_read && !w_full;

   assign o_cnt = r_cnt;
   assign o_cur = r_cur;
   assign o_err = r_err;

   // Flag any rvalid that no issued read is waiting for
   always_comb begin
      w_spurious = 1'b0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (i_rvalid[i] && (!w_busy || (r_cur != SEL_W'(i)))) begin
            w_spurious = 1'b1;
         end
      end
   end

   // Count issued-but-unanswered reads; a push and a pop in one cycle cancel
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_cur <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_push && !o_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (o_pop && !w_push) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_push) begin
            r_cur <= i_sel;
         end
         if (w_spurious || (i_accept && i_decerr)) begin
            r_err <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/iob_dbus_split.sv
// rtl/iob_dbus_split.sv - address-decoded IOb splitter, in-order reads; IOB_DBUS_SPLIT_DECERR_EN adds decode errors
module iob_dbus_split
   import iob_dbus_split_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int N_SLAVES  = 4,
   parameter int SEL_W     = 2,
   parameter int SEL_MSB   = ADDR_W - 2,
   parameter int MAX_OUTST = 4
) (
   input  logic             clk,
   input  logic             rst,
   iob_dbus_split_if.slave  bus,
   output logic             err
);
   localparam int REQ_W  = req_w(ADDR_W, DATA_W);
   localparam int RESP_W = resp_w(DATA_W);
   localparam int VLD_B  = req_valid_bit(ADDR_W, DATA_W);
   localparam int SEL_B  = req_addr_lsb(DATA_W) + SEL_MSB;
   localparam int STB_W  = DATA_W / 8;
   localparam int N_IDX  = 2 ** SEL_W;
   localparam int CNT_W  = $clog2(MAX_OUTST + 1);
   localparam logic [SEL_W:0]   LP_NS   = (SEL_W + 1)'(N_SLAVES);
   localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_SLAVES - 1);

   logic              w_m_valid;
   logic              w_is_read;
   logic              w_out_of_range;
   logic              w_decerr;
   logic              w_sel_ready;
   logic              w_stall;
   logic              w_ready;
   logic              w_accept;
   logic              w_pop;
   logic              w_cur_null;
   logic              w_null_vld;
   logic              w_cur_rvalid;
   logic [SEL_W-1:0]  w_sel_raw;
   logic [SEL_W-1:0]  w_sel;
   logic [SEL_W-1:0]  w_cur;
   logic [CNT_W-1:0]  w_cnt;
   logic [N_IDX-1:0]  w_rdy_v;
   logic [N_IDX-1:0]  w_rvld_v;
   logic [DATA_W-1:0] w_rdata_a [N_IDX];
   logic [DATA_W-1:0] w_rdata;

   assign w_m_valid      = bus.m_req[VLD_B];
   assign w_sel_raw      = bus.m_req[SEL_B -: SEL_W];
   assign w_is_read      = (bus.m_req[STB_W-1:0] == '0);
   assign w_out_of_range = ({1'b0, w_sel_raw} >= LP_NS);

   // Unpack slave responses; unused select codes read as idle
   for (genvar g = 0; g < N_IDX; g++) begin : g_resp
      if (g < N_SLAVES) begin : g_used
         assign w_rdy_v[g]   = bus.s_resp[g*RESP_W + RESP_READY_BIT];
         assign w_rvld_v[g]  = bus.s_resp[g*RESP_W + RESP_RVALID_BIT];
         assign w_rdata_a[g] = bus.s_resp[g*RESP_W + RESP_RDATA_LSB +: DATA_W];
      end else begin : g_unused
         assign w_rdy_v[g]   = 1'b0;
         assign w_rvld_v[g]  = 1'b0;
         assign w_rdata_a[g] = '0;
      end
   end

`ifdef IOB_DBUS_SPLIT_DECERR_EN
   logic r_null_vld;

   assign w_decerr   = w_out_of_range;
   assign w_sel      = w_sel_raw;
   assign w_cur_null = ({1'b0, w_cur} >= LP_NS);
   assign w_null_vld = r_null_vld;

   // One-entry responder answering unmapped reads with zero one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         r_null_vld <= 1'b0;
      end else begin
         r_null_vld <= w_accept && w_is_read && w_decerr;
      end
   end
`else
   assign w_decerr   = 1'b0;
   assign w_sel      = w_out_of_range ? LP_LAST : w_sel_raw;
   assign w_cur_null = 1'b0;
   assign w_null_vld = 1'b0;
`endif

   assign w_sel_ready = w_decerr | w_rdy_v[w_sel];
   assign w_ready     = w_sel_ready & ~w_stall & ~rst;
   assign w_accept    = w_m_valid & w_ready;

   // Address/data/strobe fan out to every slave; only the selected one sees valid
   for (genvar g = 0; g < N_SLAVES; g++) begin : g_req
      assign bus.s_req[g*REQ_W +: REQ_W] =
         {w_m_valid & ~w_stall & ~rst & ~w_decerr & (w_sel == SEL_W'(g)), bus.m_req[VLD_B-1:0]};
   end

   assign w_cur_rvalid = w_cur_null ? w_null_vld : w_rvld_v[w_cur];
   assign w_rdata      = w_cur_null ? '0 : w_rdata_a[w_cur];
   assign bus.m_resp   = {w_rdata, w_pop, w_ready};

   iob_dbus_split_track #(
      .SEL_W     (SEL_W),
      .N_SLAVES  (N_SLAVES),
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
   ) u_track (
      .clk          (clk),
      .rst          (rst),
      .i_sel        (w_sel),
      .i_is_read    (w_is_read),
      .i_accept     (w_accept),
      .i_decerr     (w_decerr),
      .i_rvalid     (w_rvld_v[N_SLAVES-1:0]),
      .i_cur_rvalid (w_cur_rvalid),
      .o_stall      (w_stall),
      .o_pop        (w_pop),
      .o_cnt        (w_cnt),
      .o_cur        (w_cur),
      .o_err        (err)
   );
endmodule
